// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_prog
//  Brief    : Programmable 50%-duty clock divider for any integer N >= 2.
//             Odd N adds a negedge flop to stretch the high phase by half a
//             source period. Supports runtime divisor reload at period
//             boundaries, glitch-free enable/disable and a per-period tick.
//  Revision : 1.0  initial release
// ============================================================================
module clk_div_prog #(
    parameter int DIV_WIDTH   = 8,
    parameter int DEFAULT_DIV = 3
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div_in,
    input  logic                 div_load,
    output logic                 clk_out,
    output logic                 tick,
    output logic                 busy,
    output logic                 div_err
);

    localparam logic [DIV_WIDTH-1:0] C_DEFAULT = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] C_ZERO    = '0;
    localparam logic [DIV_WIDTH-1:0] C_ONE     = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] C_TWO     = DIV_WIDTH'(2);

    // Registered state
    logic                 run_q,        run_d;
    logic [DIV_WIDTH-1:0] cnt_q,        cnt_d;
    logic                 pos_hi_q,     pos_hi_d;
    logic                 neg_hi_q;
    logic [DIV_WIDTH-1:0] active_div_q, active_div_d;
    logic [DIV_WIDTH-1:0] pend_div_q,   pend_div_d;
    logic                 pend_vld_q,   pend_vld_d;
    logic                 tick_q,       tick_d;
    logic                 div_err_q,    div_err_d;

    // Combinational helpers
    logic [DIV_WIDTH-1:0] w_half;
    logic [DIV_WIDTH-1:0] w_last;
    logic [DIV_WIDTH-1:0] w_cnt_inc;
    logic                 w_wrap;
    logic                 w_load_ok;
    logic                 w_load_bad;
    logic                 w_apply;

    // Derived divisor quantities; cnt never exceeds N-1 so cnt+1 cannot overflow
    always_comb begin
        w_half     = active_div_q >> 1;
        w_last     = active_div_q - C_ONE;
        w_cnt_inc  = cnt_q + C_ONE;
        w_wrap     = (cnt_q == w_last);
        w_load_ok  = div_load && (div_in >= C_TWO);
        w_load_bad = div_load && (div_in <  C_TWO);
    end

    // Next-state: counter, run control, posedge high phase, divisor reload
    always_comb begin
        run_d        = run_q;
        cnt_d        = cnt_q;
        pos_hi_d     = pos_hi_q;
        tick_d       = 1'b0;
        active_div_d = active_div_q;
        pend_div_d   = pend_div_q;
        pend_vld_d   = pend_vld_q;
        div_err_d    = w_load_bad;
        w_apply      = 1'b0;

        if (run_q) begin
            if (w_wrap) begin
                // Period boundary: swap in a pending divisor so the very next
                // period already uses it; H >= 1 so the new period starts high.
                w_apply = pend_vld_q;
                cnt_d   = C_ZERO;
                if (en) begin
                    pos_hi_d = 1'b1;
                    tick_d   = 1'b1;
                end else begin
                    run_d    = 1'b0;
                    pos_hi_d = 1'b0;
                end
            end else begin
                cnt_d    = w_cnt_inc;
                pos_hi_d = (w_cnt_inc < w_half);
            end
        end else if (en) begin
            // Start from idle: output rises at the same edge en is sampled
            run_d    = 1'b1;
            cnt_d    = C_ZERO;
            pos_hi_d = 1'b1;
            tick_d   = 1'b1;
            w_apply  = pend_vld_q;
        end else begin
            cnt_d    = C_ZERO;
            pos_hi_d = 1'b0;
        end

        if (w_apply) begin
            active_div_d = pend_div_q;
            pend_vld_d   = 1'b0;
        end

        // A load in the boundary cycle wins over the clear above and stays
        // pending for the following boundary.
        if (w_load_ok) begin
            pend_div_d = div_in;
            pend_vld_d = 1'b1;
        end
    end

    // Posedge state register with asynchronous reset
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            run_q        <= 1'b0;
            cnt_q        <= C_ZERO;
            pos_hi_q     <= 1'b0;
            active_div_q <= C_DEFAULT;
            pend_div_q   <= C_ZERO;
            pend_vld_q   <= 1'b0;
            tick_q       <= 1'b0;
            div_err_q    <= 1'b0;
        end else begin
            run_q        <= run_d;
            cnt_q        <= cnt_d;
            pos_hi_q     <= pos_hi_d;
            active_div_q <= active_div_d;
            pend_div_q   <= pend_div_d;
            pend_vld_q   <= pend_vld_d;
            tick_q       <= tick_d;
            div_err_q    <= div_err_d;
        end
    end

    // Negedge flop delays the high phase by half a period, odd divisors only
    always_ff @(negedge clk_in or posedge rst) begin
        if (rst) begin
            neg_hi_q <= 1'b0;
        end else begin
            neg_hi_q <= active_div_q[0] & pos_hi_q;
        end
    end

    // Outputs are direct flop values; clk_out is an OR of two flops only
    always_comb begin
        clk_out = pos_hi_q | neg_hi_q;
        tick    = tick_q;
        busy    = pend_vld_q;
        div_err = div_err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_div_prog
//  Brief    : Directed self-checking bench for clk_div_prog.
//  Revision : 1.0  initial release
// ============================================================================
module tb_clk_div_prog;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] div_in;
    logic       div_load;
    logic       clk_out;
    logic       tick;
    logic       busy;
    logic       div_err;

    int total = 0;
    int bad   = 0;

    // Samples of one source cycle: after posedge (p) and after negedge (n)
    logic sp, sn, st, sb, se;

    clk_div_prog #(.DIV_WIDTH(8), .DEFAULT_DIV(3)) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .en       (en),
        .div_in   (div_in),
        .div_load (div_load),
        .clk_out  (clk_out),
        .tick     (tick),
        .busy     (busy),
        .div_err  (div_err)
    );

    always #5 clk_in = ~clk_in;

    // Expected clk_out in cycle k of a period of N: high k<=H for odd N
    // in the first half-cycle (negedge stretch), k<H otherwise.
    function automatic logic exp_p(int n, int k);
        return (k < n / 2) || ((n % 2 == 1) && (k == n / 2));
    endfunction

    function automatic logic exp_n(int n, int k);
        return (k < n / 2);
    endfunction

    task automatic cyc();
        @(posedge clk_in);
        #1;
        sp = clk_out; st = tick; sb = busy; se = div_err;
        @(negedge clk_in);
        #1;
        sn = clk_out;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; div_in = 8'd0; div_load = 1'b0;
        cyc(); cyc();
        total++;
        if ({sp, sn, st, sb, se} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=00000", {sp, sn, st, sb, se});
        end
        rst = 1'b0;
        cyc();
        total++;
        if ({sp, sn, st} !== 3'b0) begin
            bad++;
            $display("FAIL idle_no_en got=%b want=000", {sp, sn, st});
        end
    endtask

    task automatic test_default_div3();
        en = 1'b1;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 3; k++) begin
                cyc();
                total += 3;
                if (sp !== exp_p(3, k)) begin bad++; $display("FAIL t1_hi_p p%0d k%0d got=%b want=%b", p, k, sp, exp_p(3, k)); end
                if (sn !== exp_n(3, k)) begin bad++; $display("FAIL t1_hi_n p%0d k%0d got=%b want=%b", p, k, sn, exp_n(3, k)); end
                if (st !== (k == 0))    begin bad++; $display("FAIL t1_tick p%0d k%0d got=%b want=%b", p, k, st, (k == 0)); end
            end
        end
    endtask

    task automatic test_reload_4();
        div_in = 8'd4; div_load = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            div_load = 1'b0;
            total += 2;
            if (sp !== exp_p(3, k) || sn !== exp_n(3, k)) begin
                bad++; $display("FAIL t2_old_period k%0d got=%b%b want=%b%b", k, sp, sn, exp_p(3, k), exp_n(3, k));
            end
            if (sb !== 1'b1) begin bad++; $display("FAIL t2_busy_pending k%0d got=%b want=1", k, sb); end
        end
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 4; k++) begin
                cyc();
                total += 3;
                if (sp !== exp_p(4, k) || sn !== exp_n(4, k)) begin
                    bad++; $display("FAIL t2_n4 p%0d k%0d got=%b%b want=%b%b", p, k, sp, sn, exp_p(4, k), exp_n(4, k));
                end
                if (st !== (k == 0)) begin bad++; $display("FAIL t2_tick p%0d k%0d got=%b want=%b", p, k, st, (k == 0)); end
                if (sb !== 1'b0)     begin bad++; $display("FAIL t2_busy_clear p%0d k%0d got=%b want=0", p, k, sb); end
            end
        end
    endtask

    task automatic test_reload_7_mid();
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin div_in = 8'd7; div_load = 1'b1; end
            cyc();
            div_load = 1'b0;
            total += 2;
            if (sp !== exp_p(4, k) || sn !== exp_n(4, k)) begin
                bad++; $display("FAIL t3_n4_intact k%0d got=%b%b want=%b%b", k, sp, sn, exp_p(4, k), exp_n(4, k));
            end
            if (sb !== (k >= 2)) begin bad++; $display("FAIL t3_busy k%0d got=%b want=%b", k, sb, (k >= 2)); end
        end
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 7; k++) begin
                cyc();
                total += 2;
                if (sp !== exp_p(7, k) || sn !== exp_n(7, k)) begin
                    bad++; $display("FAIL t3_n7 p%0d k%0d got=%b%b want=%b%b", p, k, sp, sn, exp_p(7, k), exp_n(7, k));
                end
                if (st !== (k == 0)) begin bad++; $display("FAIL t3_tick p%0d k%0d got=%b want=%b", p, k, st, (k == 0)); end
            end
        end
    endtask

    task automatic test_bad_load();
        div_in = 8'd1; div_load = 1'b1;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 7; k++) begin
                cyc();
                div_load = 1'b0;
                total += 3;
                if (se !== (p == 0 && k == 0)) begin bad++; $display("FAIL t4_div_err p%0d k%0d got=%b want=%b", p, k, se, (p == 0 && k == 0)); end
                if (sb !== 1'b0) begin bad++; $display("FAIL t4_busy p%0d k%0d got=%b want=0", p, k, sb); end
                if (sp !== exp_p(7, k) || sn !== exp_n(7, k)) begin
                    bad++; $display("FAIL t4_n7_kept p%0d k%0d got=%b%b want=%b%b", p, k, sp, sn, exp_p(7, k), exp_n(7, k));
                end
            end
        end
    endtask

    task automatic test_stop_restart();
        // Load in the boundary cycle: stays pending for a full N=7 period
        div_in = 8'd5; div_load = 1'b1;
        for (int k = 0; k < 7; k++) begin
            cyc();
            div_load = 1'b0;
            total += 1;
            if (sp !== exp_p(7, k) || sn !== exp_n(7, k) || sb !== 1'b1) begin
                bad++; $display("FAIL t5_n7_pending k%0d got=%b%b%b want=%b%b1", k, sp, sn, sb, exp_p(7, k), exp_n(7, k));
            end
        end
        for (int k = 0; k < 5; k++) begin
            if (k == 1) en = 1'b0;
            cyc();
            total += 1;
            if (sp !== exp_p(5, k) || sn !== exp_n(5, k)) begin
                bad++; $display("FAIL t5_finish k%0d got=%b%b want=%b%b", k, sp, sn, exp_p(5, k), exp_n(5, k));
            end
        end
        for (int k = 0; k < 3; k++) begin
            cyc();
            total += 1;
            if ({sp, sn, st} !== 3'b000) begin bad++; $display("FAIL t5_held_low k%0d got=%b want=000", k, {sp, sn, st}); end
        end
        en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            total += 2;
            if (sp !== exp_p(5, k % 5) || sn !== exp_n(5, k % 5)) begin
                bad++; $display("FAIL t5_restart k%0d got=%b%b want=%b%b", k, sp, sn, exp_p(5, k % 5), exp_n(5, k % 5));
            end
            if (st !== (k % 5 == 0)) begin bad++; $display("FAIL t5_tick k%0d got=%b want=%b", k, st, (k % 5 == 0)); end
        end
    endtask

    task automatic test_async_reset();
        div_in = 8'd6; div_load = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            div_load = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            if (k == 1) begin div_in = 8'd9; div_load = 1'b1; end
            cyc();
            div_load = 1'b0;
            total += 1;
            if (sp !== exp_p(6, k) || sn !== exp_n(6, k)) begin
                bad++; $display("FAIL t6_n6 k%0d got=%b%b want=%b%b", k, sp, sn, exp_p(6, k), exp_n(6, k));
            end
        end
        #2 rst = 1'b1;
        #1;
        total += 1;
        if ({clk_out, tick, busy} !== 3'b000) begin
            bad++; $display("FAIL t6_async_clear got=%b want=000", {clk_out, tick, busy});
        end
        cyc(); cyc();
        total += 1;
        if ({sp, sn, st, sb} !== 4'b0) begin bad++; $display("FAIL t6_in_reset got=%b want=0000", {sp, sn, st, sb}); end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            total += 2;
            if (sp !== exp_p(3, k % 3) || sn !== exp_n(3, k % 3)) begin
                bad++; $display("FAIL t6_default_n3 k%0d got=%b%b want=%b%b", k, sp, sn, exp_p(3, k % 3), exp_n(3, k % 3));
            end
            if (st !== (k % 3 == 0) || sb !== 1'b0) begin
                bad++; $display("FAIL t6_tick_busy k%0d got=%b%b want=%b0", k, st, sb, (k % 3 == 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_div3();
        test_reload_4();
        test_reload_7_mid();
        test_bad_load();
        test_stop_restart();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
